// File: rtl/cad_pkg.sv
// ---------------------------------------------------------------------------
// cad_pkg
// Shared definitions for the operand fetch front end of the MAC pipeline.
//   DEFAULT_DATA_W : default width of IFmap and filter operands
//   state_t        : operand_fetch_ctrl FSM encoding (IDLE/FETCH/DRAIN/DONE)
// ---------------------------------------------------------------------------
package cad_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/operand_buf.sv
// ---------------------------------------------------------------------------
// operand_buf
// Two-entry synchronous FIFO holding {ifmap, filter, last} operand triples.
// Entry 0 is always the head, so dout comes straight from a register and
// simply holds its last value once the buffer runs empty.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high clear
//   clr   : synchronous clear, wins over push/pop
//   push  : write din (ignored when full unless popping in the same cycle)
//   pop   : drop the head (ignored when empty)
//   din   : payload to push
//   dout  : head payload
//   count : number of valid entries (0..2)
// ---------------------------------------------------------------------------
module operand_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] entry0_q;
    logic [W-1:0] entry1_q;
    logic [1:0]   count_q;
    logic         popOk;
    logic         pushOk;

    // A push into a full buffer is only legal when the head leaves at the
    // same edge.
    assign popOk  = pop && (count_q != 2'd0);
    assign pushOk = push && ((count_q != 2'd2) || popOk);

    // Shift-style storage: a pop moves entry 1 down into entry 0, so the
    // head never has to be selected through a read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else if (clr) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else if (popOk && pushOk) begin
            if (count_q == 2'd2) begin
                entry0_q <= entry1_q;
                entry1_q <= din;
            end else begin
                entry0_q <= din;
            end
        end else if (popOk) begin
            if (count_q == 2'd2) begin
                entry0_q <= entry1_q;
            end
            count_q <= count_q - 2'd1;
        end else if (pushOk) begin
            if (count_q == 2'd0) begin
                entry0_q <= din;
            end else begin
                entry1_q <= din;
            end
            count_q <= count_q + 2'd1;
        end
    end

    assign dout  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/operand_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// operand_fetch_ctrl
// Pops IFmap elements from a first-word-fall-through FIFO, pairs each with
// its filter coefficient and queues the pairs for the MAC pipeline. A job is
// NUM_WIN windows of FILT_LEN elements; the last element of each window is
// flagged, and done pulses once the job has fully drained.
//   clk, rst   : clock / asynchronous active-high reset
//   inner_rst  : synchronous clear, highest priority at the edge
//   start      : begin a job (only seen in IDLE)
//   if_empty, if_data, if_rd_en : input FIFO interface (FWFT)
//   filt_addr, filt_data        : filter register file lookup
//   ld_mult    : consumer takes the head pair
//   can_mult, a_out, b_out, last_out : head pair and its valid flag
//   busy, done : job status
// ---------------------------------------------------------------------------
module operand_fetch_ctrl
    import cad_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int FILT_LEN = 4,
    parameter int NUM_WIN  = 2,
    parameter int ADDR_W   = 2,
    parameter int WIN_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inner_rst,
    input  logic              start,
    input  logic              if_empty,
    input  logic [DATA_W-1:0] if_data,
    output logic              if_rd_en,
    output logic [ADDR_W-1:0] filt_addr,
    input  logic [DATA_W-1:0] filt_data,
    input  logic              ld_mult,
    output logic              can_mult,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              last_out,
    output logic              busy,
    output logic              done
);

    localparam int                PAY_W     = 2 * DATA_W + 1;
    localparam logic [ADDR_W-1:0] ELEM_LAST = ADDR_W'(FILT_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(NUM_WIN - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] elem_cnt_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [1:0]        bufCount;
    logic [PAY_W-1:0]  bufDin;
    logic [PAY_W-1:0]  bufDout;
    logic              fetch;
    logic              pop;
    logic              lastElem;

    assign lastElem = (elem_cnt_q == ELEM_LAST);

    // Fetch eligibility looks only at occupancy, never at ld_mult, so there
    // is no combinational path from the consumer back to the FIFO pop.
    // inner_rst blocks the pop so no element is lost to the clear.
    assign fetch    = (state_q == FETCH) && !if_empty && (bufCount != 2'd2) && !inner_rst;
    assign pop      = ld_mult && (bufCount != 2'd0);
    assign bufDin   = {if_data, filt_data, lastElem};

    // Job sequencing: element/window counters advance only on a real fetch;
    // the final fetch of the last window hands over to DRAIN, which waits
    // for the consumer to empty the buffer before the one-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            win_cnt_q  <= '0;
        end else if (inner_rst) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            win_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        elem_cnt_q <= '0;
                        win_cnt_q  <= '0;
                    end
                end
                FETCH: begin
                    if (fetch) begin
                        if (lastElem) begin
                            elem_cnt_q <= '0;
                            if (win_cnt_q == WIN_LAST) begin
                                win_cnt_q <= '0;
                                state_q   <= DRAIN;
                            end else begin
                                win_cnt_q <= win_cnt_q + WIN_W'(1);
                            end
                        end else begin
                            elem_cnt_q <= elem_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bufCount == 2'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    operand_buf #(
        .W(PAY_W)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (inner_rst),
        .push (fetch),
        .pop  (pop),
        .din  (bufDin),
        .dout (bufDout),
        .count(bufCount)
    );

    assign if_rd_en  = fetch;
    assign filt_addr = elem_cnt_q;
    assign can_mult  = (bufCount != 2'd0);
    assign a_out     = bufDout[PAY_W-1 -: DATA_W];
    assign b_out     = bufDout[DATA_W:1];
    assign last_out  = bufDout[0];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_ctrl
// Directed bench for operand_fetch_ctrl with FILT_LEN=4, NUM_WIN=2. The input
// FIFO holds 1..8 and the filter file holds 10,20,30,40, so pair k (0-based)
// is expected to be (k+1, 10*(k%4+1)) with last set when k%4==3.
// ---------------------------------------------------------------------------
module tb_operand_fetch_ctrl;

    logic       clk;
    logic       rst;
    logic       inner_rst;
    logic       start;
    logic       if_empty;
    logic [7:0] if_data;
    logic       if_rd_en;
    logic [1:0] filt_addr;
    logic [7:0] filt_data;
    logic       ld_mult;
    logic       can_mult;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       last_out;
    logic       busy;
    logic       done;

    int total;
    int bad;
    int rdIdx;
    logic forceEmpty;

    operand_fetch_ctrl #(
        .DATA_W  (8),
        .FILT_LEN(4),
        .NUM_WIN (2),
        .ADDR_W  (2),
        .WIN_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inner_rst(inner_rst),
        .start    (start),
        .if_empty (if_empty),
        .if_data  (if_data),
        .if_rd_en (if_rd_en),
        .filt_addr(filt_addr),
        .filt_data(filt_data),
        .ld_mult  (ld_mult),
        .can_mult (can_mult),
        .a_out    (a_out),
        .b_out    (b_out),
        .last_out (last_out),
        .busy     (busy),
        .done     (done)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input FIFO model (FWFT, eight elements) and the filter register file.
    assign if_empty  = forceEmpty || (rdIdx >= 8);
    assign if_data   = (rdIdx < 8) ? 8'(rdIdx + 1) : 8'hEE;
    assign filt_data = 8'((int'(filt_addr) + 1) * 10);

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Checks that every DUT output reads as cleared.
    task automatic checkCleared(input string tag);
        checkOutput({tag, ".can_mult"}, int'(can_mult), 0);
        checkOutput({tag, ".a_out"}, int'(a_out), 0);
        checkOutput({tag, ".b_out"}, int'(b_out), 0);
        checkOutput({tag, ".last_out"}, int'(last_out), 0);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".done"}, int'(done), 0);
        checkOutput({tag, ".if_rd_en"}, int'(if_rd_en), 0);
        checkOutput({tag, ".filt_addr"}, int'(filt_addr), 0);
    endtask

    // Runs one job. mode: 0 nominal, 1 FIFO bubbles, 2 backpressure,
    // 3 start while busy, 4 inner_rst at pair 5, 5 async rst mid-FETCH.
    // Inputs change 1 ns after the rising edge; outputs are sampled on the
    // falling edge, where the pop/fetch decision for the next edge is known.
    task automatic applyStimulus(input int mode);
        int  popIdx;
        int  doneCnt;
        int  doneCyc;
        int  lastPopCyc;
        int  maxGap;
        int  bubbleCnt;
        int  stallCnt;
        bit  extraStart;
        bit  irFired;
        bit  willFetch;
        bit  willPop;
        popIdx     = 0;
        doneCnt    = 0;
        doneCyc    = -1;
        lastPopCyc = -1;
        maxGap     = 0;
        bubbleCnt  = 0;
        stallCnt   = 0;
        extraStart = 1'b0;
        irFired    = 1'b0;
        rdIdx      = 0;
        forceEmpty = 1'b0;
        ld_mult    = 1'b1;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;

        for (int cyc = 0; cyc < 300 && doneCnt == 0; cyc++) begin
            if (mode == 4 && irFired) begin
                inner_rst = 1'b0;
                checkOutput("irst.busy", int'(busy), 0);
                checkOutput("irst.can_mult", int'(can_mult), 0);
                checkOutput("irst.filt_addr", int'(filt_addr), 0);
                checkOutput("irst.if_rd_en", int'(if_rd_en), 0);
                return;
            end
            if (mode == 5 && popIdx == 3) begin
                #1 rst = 1'b1;
                #1 checkCleared("arst");
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                checkOutput("arst.staysIdle", int'(busy), 0);
                checkOutput("arst.noPair", int'(can_mult), 0);
                return;
            end

            ld_mult = 1'b1;
            start   = 1'b0;
            if (mode == 1) begin
                if (rdIdx == 2 && bubbleCnt < 3) begin
                    forceEmpty = 1'b1;
                    bubbleCnt++;
                    if (bubbleCnt == 3) begin
                        checkOutput("bubble.filt_addr", int'(filt_addr), 2);
                        checkOutput("bubble.can_mult", int'(can_mult), 0);
                    end
                end else begin
                    forceEmpty = 1'b0;
                end
            end
            if (mode == 2 && popIdx == 3 && stallCnt < 5) begin
                ld_mult = 1'b0;
                stallCnt++;
                if (stallCnt == 5) begin
                    checkOutput("stall.if_rd_en", int'(if_rd_en), 0);
                    checkOutput("stall.can_mult", int'(can_mult), 1);
                    checkOutput("stall.a_out", int'(a_out), 4);
                    checkOutput("stall.b_out", int'(b_out), 40);
                end
            end
            if (mode == 3 && popIdx == 3 && !extraStart) begin
                start      = 1'b1;
                extraStart = 1'b1;
            end
            if (mode == 4 && popIdx == 5) begin
                inner_rst = 1'b1;
                irFired   = 1'b1;
            end

            @(negedge clk);
            willFetch = if_rd_en;
            willPop   = ld_mult && can_mult;
            if (willPop) begin
                if (popIdx < 8) begin
                    checkOutput("pair.a", int'(a_out), popIdx + 1);
                    checkOutput("pair.b", int'(b_out), ((popIdx % 4) + 1) * 10);
                    checkOutput("pair.last", int'(last_out), (popIdx % 4 == 3) ? 1 : 0);
                end else begin
                    checkOutput("pair.extra", popIdx, 7);
                end
                if (lastPopCyc >= 0 && cyc - lastPopCyc > maxGap) begin
                    maxGap = cyc - lastPopCyc;
                end
                lastPopCyc = cyc;
                popIdx++;
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            @(posedge clk); #1;
            if (willFetch) begin
                rdIdx++;
            end
        end

        checkOutput("job.donePulses", doneCnt, 1);
        checkOutput("job.pairs", popIdx, 8);
        checkOutput("job.doneLag", doneCyc - lastPopCyc, 2);
        checkOutput("job.busyAfter", int'(busy), 0);
        checkOutput("job.doneOneCycle", int'(done), 0);
        checkOutput("job.fifoUsed", rdIdx, 8);
        if (mode == 0) begin
            checkOutput("job.pairPerCycle", maxGap, 1);
        end
        start = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rdIdx      = 8;
        forceEmpty = 1'b0;
        rst        = 1'b1;
        inner_rst  = 1'b0;
        start      = 1'b0;
        ld_mult    = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkCleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset.idleNoStart", int'(busy), 0);

        $display("[TB] nominal run");
        applyStimulus(0);
        $display("[TB] FIFO bubbles");
        applyStimulus(1);
        $display("[TB] backpressure");
        applyStimulus(2);
        $display("[TB] start while busy");
        applyStimulus(3);
        $display("[TB] inner_rst at pair 5");
        applyStimulus(4);
        $display("[TB] fresh job after inner_rst");
        applyStimulus(0);
        $display("[TB] async rst mid-FETCH");
        applyStimulus(5);
        $display("[TB] fresh job after rst");
        applyStimulus(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
